mem_burst_seq: RTL and testbench
================================

MEM_BURST_SEQ -- requirements
Module: mem_burst_seq

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, giving the memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the response data width.
REQ-003 The block SHALL have parameter LEN_WIDTH, default 4, giving the burst length field width (encoded beats-1).
REQ-004 The block SHALL have parameter MAX_OUTSTANDING, default 4, giving the maximum number of issued but unanswered slave requests.
REQ-005 The block SHALL have parameter WORD_BYTES, default 4, giving the address increment per beat.
REQ-006 The block SHALL have port clk, input, width 1, the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, width 1, an asynchronous active-low reset.
REQ-008 The block SHALL have port burst_req, decoupled.in, data LEN_WIDTH+ADDR_WIDTH, carrying {len, base_addr}.
REQ-009 The block SHALL have port word_resp, decoupled.out, data 1+DATA_WIDTH, carrying {last, data}.
REQ-010 The block SHALL have port slave_req, decoupled.out, data ADDR_WIDTH, carrying the per-beat word address.
REQ-011 The block SHALL have port slave_resp, decoupled.in, data DATA_WIDTH, carrying the in-order memory response.
REQ-012 The block SHALL have port busy, output, width 1, high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE and DRAIN.
REQ-014 burst_req.ready SHALL equal (state == IDLE); on burst_req fire, the block SHALL latch base_addr and len, clear the issue and receive counters, and enter ISSUE.
REQ-015 In ISSUE, slave_req.valid SHALL be high when outstanding < MAX_OUTSTANDING; slave_req.data SHALL be base_addr + issued*WORD_BYTES, truncated modulo 2^ADDR_WIDTH (wrap permitted).
REQ-016 The first slave_req.valid SHALL appear in the cycle after burst_req fire (1-cycle latency).
REQ-017 After the slave_req fire with issued == len, state SHALL move ISSUE -> DRAIN; exactly len+1 requests SHALL be issued per burst.
REQ-018 The outstanding count SHALL increment on slave_req fire, decrement on slave_resp fire, and stay unchanged when both occur in the same cycle; it SHALL never exceed MAX_OUTSTANDING.
REQ-019 In ISSUE and DRAIN, the response path SHALL be combinational: word_resp.valid = slave_resp.valid, word_resp data = slave_resp.data, slave_resp.ready = word_resp.ready.
REQ-020 word_resp last SHALL be high iff received == len.
REQ-021 On the word_resp fire with last high, state SHALL return to IDLE, and the next burst SHALL be accepted no earlier than the following cycle.
REQ-022 If the last response fires while still in ISSUE (not possible with in-order memory), the block SHALL still move to IDLE.
REQ-023 len == 0 SHALL produce exactly one request and one response, with last high.

Reset
REQ-024 While rst is low: state = IDLE, all counters = 0, slave_req.valid = 0, word_resp.valid = 0, busy = 0, burst_req.ready = 1.
REQ-025 Reset asserted mid-burst SHALL abandon the burst immediately; responses to requests issued before reset are not tracked.

Configuration
REQ-026 Macro MEM_BURST_SEQ_ERR_EN, when defined, SHALL add output port err (width 1, reset 0).
REQ-027 With MEM_BURST_SEQ_ERR_EN defined: in IDLE, slave_resp.ready SHALL be 1; a slave_resp fire in IDLE SHALL be dropped and SHALL set err sticky until reset.
REQ-028 Without MEM_BURST_SEQ_ERR_EN: there SHALL be no err port, and slave_resp.ready SHALL be 0 in IDLE.

Verification
REQ-029 Burst len=3, addr=0x1000, slave always ready with 1-cycle response -> slave addrs 0x1000, 0x1004, 0x1008, 0x100C; 4 word_resp beats with last only on the 4th; busy drops after the 4th fire.
REQ-030 len=7, MAX_OUTSTANDING=4, slave never responds -> exactly 4 slave_req fires, then slave_req.valid stays 0; each later response releases one more request.
REQ-031 addr=0xFFFFFFF8, len=3 -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-032 word_resp.ready held 0 for 5 cycles mid-burst -> slave_resp.ready stays 0, and the data and last of the stalled beat stay stable.
REQ-033 rst pulsed low after 2 of 4 beats -> all valids 0 and busy 0 immediately; a new burst len=0 is accepted after release and completes with one beat, last=1.
REQ-034 ERR_EN build: slave_resp.valid pulsed in IDLE -> accepted, no word_resp.valid, err = 1 until rst.

Source files
------------

// File: rtl/mem_burst_seq.sv
// Burst-to-word read sequencer: expands {len, base_addr} into len+1 word requests and streams responses back with last.
// Optional err output (sticky, spurious response while idle) enabled by defining MEM_BURST_SEQ_ERR_EN.
module mem_burst_seq #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int WORD_BYTES      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            burst_req_valid,
    output logic                            burst_req_ready,
    input  logic [LEN_WIDTH+ADDR_WIDTH-1:0] burst_req_data,
    output logic                            word_resp_valid,
    input  logic                            word_resp_ready,
    output logic [DATA_WIDTH:0]             word_resp_data,
    output logic                            slave_req_valid,
    input  logic                            slave_req_ready,
    output logic [ADDR_WIDTH-1:0]           slave_req_data,
    input  logic                            slave_resp_valid,
    output logic                            slave_resp_ready,
    input  logic [DATA_WIDTH-1:0]           slave_resp_data,
    output logic                            busy
`ifdef MEM_BURST_SEQ_ERR_EN
    ,
    output logic                            err
`endif
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic [LEN_WIDTH-1:0]  r_recv;
    logic [OUT_W-1:0]      r_outst;

    logic w_active;
    logic w_last;
    logic w_burst_fire;
    logic w_req_fire;
    logic w_word_fire;

    always_comb begin
        w_active        = (r_state != IDLE);
        burst_req_ready = (r_state == IDLE);
        busy            = w_active;
        slave_req_valid = (r_state == ISSUE) && (r_outst < OUT_W'(MAX_OUTSTANDING));
        // Address arithmetic deliberately wraps at 2^ADDR_WIDTH.
        slave_req_data  = r_base + ADDR_WIDTH'(r_issued) * ADDR_WIDTH'(WORD_BYTES);
        w_last          = (r_recv == r_len);
        word_resp_valid = w_active & slave_resp_valid;
        word_resp_data  = {w_active & w_last, slave_resp_data};
`ifdef MEM_BURST_SEQ_ERR_EN
        slave_resp_ready = w_active ? word_resp_ready : 1'b1;
`else
        slave_resp_ready = w_active & word_resp_ready;
`endif
        w_burst_fire = burst_req_valid & burst_req_ready;
        w_req_fire   = slave_req_valid & slave_req_ready;
        w_word_fire  = word_resp_valid & word_resp_ready;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_burst_fire) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                // A final response seen here still ends the burst.
                if (w_word_fire && w_last)                w_state_nxt = IDLE;
                else if (w_req_fire && r_issued == r_len) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_word_fire && w_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base   <= '0;
            r_len    <= '0;
            r_issued <= '0;
            r_recv   <= '0;
            r_outst  <= '0;
        end else if (w_burst_fire) begin
            r_base   <= burst_req_data[ADDR_WIDTH-1:0];
            r_len    <= burst_req_data[LEN_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
            r_issued <= '0;
            r_recv   <= '0;
            r_outst  <= '0;
        end else begin
            if (w_req_fire && r_issued != r_len) r_issued <= r_issued + 1'b1;
            if (w_word_fire)                     r_recv   <= r_recv + 1'b1;
            if (w_req_fire && !w_word_fire) begin
                r_outst <= r_outst + 1'b1;
            end else if (!w_req_fire && w_word_fire && r_outst != '0) begin
                r_outst <= r_outst - 1'b1;
            end
        end
    end

`ifdef MEM_BURST_SEQ_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (slave_resp_valid && slave_resp_ready && !w_active) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_burst_seq.sv
// Bench for mem_burst_seq: constant-vector bursts, directed corner sequences and randomized bursts vs. a queue model.
module tb_mem_burst_seq;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        burst_req_valid = 1'b0;
    logic        burst_req_ready;
    logic [35:0] burst_req_data = '0;
    logic        word_resp_valid;
    logic        word_resp_ready = 1'b0;
    logic [32:0] word_resp_data;
    logic        slave_req_valid;
    logic        slave_req_ready = 1'b0;
    logic [31:0] slave_req_data;
    logic        slave_resp_valid = 1'b0;
    logic        slave_resp_ready;
    logic [31:0] slave_resp_data = '0;
    logic        busy;
`ifdef MEM_BURST_SEQ_ERR_EN
    logic        err;
`endif

    mem_burst_seq dut (
        .clk             (clk),
        .rst             (rst),
        .burst_req_valid (burst_req_valid),
        .burst_req_ready (burst_req_ready),
        .burst_req_data  (burst_req_data),
        .word_resp_valid (word_resp_valid),
        .word_resp_ready (word_resp_ready),
        .word_resp_data  (word_resp_data),
        .slave_req_valid (slave_req_valid),
        .slave_req_ready (slave_req_ready),
        .slave_req_data  (slave_req_data),
        .slave_resp_valid(slave_resp_valid),
        .slave_resp_ready(slave_resp_ready),
        .slave_resp_data (slave_resp_data),
        .busy            (busy)
`ifdef MEM_BURST_SEQ_ERR_EN
        ,
        .err             (err)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state for the burst in flight.
    int          m_len;
    logic [31:0] m_base;
    int          m_issued;
    int          m_recv;
    int          m_outst;
    int          m_nlast;
    logic [31:0] m_first;
    logic [31:0] m_lastaddr;
    logic [32:0] m_wdat_seen;
    logic        m_wvld_seen;
    logic [31:0] pend[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] exp_addr(input int i);
        return m_base + 32'(i) * 32'd4;
    endfunction

    task automatic start_burst(input int len, input logic [31:0] base);
        @(negedge clk);
        burst_req_valid  = 1'b1;
        burst_req_data   = {4'(len), base};
        slave_req_ready  = 1'b0;
        slave_resp_valid = 1'b0;
        #1;
        chk("burst_ready", burst_req_ready, 1);
        @(posedge clk);
        #1;
        burst_req_valid = 1'b0;
        m_len = len; m_base = base; m_issued = 0; m_recv = 0; m_outst = 0; m_nlast = 0;
        pend.delete();
    endtask

    task automatic step(input int rq, input int rs, input int wr);
        logic rf, wf;
        @(negedge clk);
        slave_req_ready = ($urandom_range(99) < rq);
        word_resp_ready = ($urandom_range(99) < wr);
        if (pend.size() > 0 && $urandom_range(99) < rs) begin
            slave_resp_valid = 1'b1;
            slave_resp_data  = mem_data(pend[0]);
        end else begin
            slave_resp_valid = 1'b0;
            slave_resp_data  = $urandom();
        end
        #1;
        chk("busy", busy, 1);
        chk("req_vld", slave_req_valid, (m_issued <= m_len && m_outst < MAXO));
        chk("wr_vld", word_resp_valid, slave_resp_valid);
        chk("sr_rdy", slave_resp_ready, word_resp_ready);
        rf = slave_req_valid & slave_req_ready;
        wf = word_resp_valid & word_resp_ready;
        if (rf) chk("req_addr", slave_req_data, exp_addr(m_issued));
        if (word_resp_valid) begin
            chk("wr_data", word_resp_data[31:0], mem_data(exp_addr(m_recv)));
            chk("wr_last", word_resp_data[32], (m_recv == m_len));
        end
        m_wdat_seen = word_resp_data;
        m_wvld_seen = word_resp_valid;
        @(posedge clk);
        if (rf) begin
            if (m_issued == 0)     m_first    = slave_req_data;
            if (m_issued == m_len) m_lastaddr = slave_req_data;
            pend.push_back(slave_req_data);
            m_issued++;
            m_outst++;
        end
        if (wf) begin
            if (word_resp_data[32]) m_nlast++;
            if (pend.size() > 0) void'(pend.pop_front());
            m_recv++;
            m_outst--;
        end
    endtask

    task automatic finish_burst(input int rq, input int rs, input int wr);
        int cyc = 0;
        while (m_recv <= m_len && cyc < 600) begin
            step(rq, rs, wr);
            cyc++;
        end
        chk("burst_done", m_recv, m_len + 1);
        chk("issued_total", m_issued, m_len + 1);
        chk("last_count", m_nlast, 1);
        @(negedge clk);
        slave_resp_valid = 1'b0;
        #1;
        chk("busy_after", busy, 0);
        chk("ready_after", burst_req_ready, 1);
    endtask

    typedef struct {
        int          len;
        logic [31:0] base;
        logic [31:0] first;
        logic [31:0] lastaddr;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int fires;
        logic [32:0] prev;

        tbl[0] = '{3,  32'h0000_1000, 32'h0000_1000, 32'h0000_100C};
        tbl[1] = '{3,  32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h0000_0004};
        tbl[2] = '{0,  32'h0000_0020, 32'h0000_0020, 32'h0000_0020};
        tbl[3] = '{15, 32'h0000_0000, 32'h0000_0000, 32'h0000_003C};

        #1;
        chk("rst_busy", busy, 0);
        chk("rst_breq_rdy", burst_req_ready, 1);
        chk("rst_sreq_vld", slave_req_valid, 0);
        chk("rst_wr_vld", word_resp_valid, 0);
`ifdef MEM_BURST_SEQ_ERR_EN
        chk("rst_err", err, 0);
`endif
        #20;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            start_burst(tbl[i].len, tbl[i].base);
            finish_burst(100, 100, 100);
            chk("tbl_first", m_first, tbl[i].first);
            chk("tbl_last", m_lastaddr, tbl[i].lastaddr);
        end

        // Slave never answers: window closes at MAX_OUTSTANDING, each response reopens it by one.
        start_burst(7, 32'h0000_4000);
        for (int k = 0; k < 10; k++) step(100, 0, 100);
        chk("win_fires", m_issued, MAXO);
        chk("win_vld", slave_req_valid, 0);
        step(100, 100, 100);
        fires = m_issued;
        step(100, 0, 100);
        step(100, 0, 100);
        chk("win_release", m_issued, fires + 1);
        finish_burst(100, 100, 100);

        // Downstream stall mid-burst.
        start_burst(3, 32'h0000_0300);
        for (int k = 0; k < 20 && m_recv < 1; k++) step(100, 100, 100);
        prev = '0;
        for (int k = 0; k < 5; k++) begin
            step(100, 100, 0);
            chk("stall_vld", m_wvld_seen, 1);
            if (k > 0) chk("stall_stable", m_wdat_seen, prev);
            prev = m_wdat_seen;
        end
        finish_burst(100, 100, 100);

        // Reset mid-burst, then a single-beat burst.
        start_burst(3, 32'h0000_0500);
        for (int k = 0; k < 20 && m_recv < 2; k++) step(100, 100, 100);
        @(negedge clk);
        rst = 1'b0;
        slave_req_ready = 1'b1;
        word_resp_ready = 1'b1;
        #1;
        chk("mid_rst_sreq_vld", slave_req_valid, 0);
        chk("mid_rst_wr_vld", word_resp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_breq_rdy", burst_req_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        slave_resp_valid = 1'b0;
        start_burst(0, 32'h0000_0600);
        finish_burst(100, 100, 100);

        for (int b = 0; b < 30; b++) begin
            start_burst(int'($urandom_range(15)), $urandom());
            finish_burst(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                         int'($urandom_range(100, 30)));
        end

`ifdef MEM_BURST_SEQ_ERR_EN
        @(negedge clk);
        slave_resp_valid = 1'b1;
        slave_resp_data  = 32'hDEAD_BEEF;
        #1;
        chk("err_idle_rdy", slave_resp_ready, 1);
        chk("err_no_wr_vld", word_resp_valid, 0);
        @(negedge clk);
        slave_resp_valid = 1'b0;
        #1;
        chk("err_set", err, 1);
        @(negedge clk);
        #1;
        chk("err_sticky", err, 1);
        rst = 1'b0;
        #1;
        chk("err_clear", err, 0);
        @(negedge clk);
        rst = 1'b1;
`else
        @(negedge clk);
        slave_resp_valid = 1'b1;
        #1;
        chk("idle_resp_rdy", slave_resp_ready, 0);
        chk("idle_wr_vld", word_resp_valid, 0);
        slave_resp_valid = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
